processor_controller: RTL and testbench
=======================================

Name: processor_controller

Overview:
- Moore-style control unit for the 16-bit programmable processor.
- Owns the program counter (PC) and instruction register (IR).
- Fetches from instruction ROM, decodes the opcode, and drives the datapath strobes each cycle: data-memory address/write, register-file read/write addresses, register-file mux select, ALU function.
- Sits between instruction ROM and datapath inside the processor top level.

Parameters:
- PC_W, 5, PC and instruction-ROM address width (32 instructions).
- IR_W, 16, instruction width.
- DA_W, 8, data-memory address width.
- RA_W, 4, register-file address width (16 registers).

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- IM_Data  input  IR_W  instruction-ROM read data; combinational for address PC_Out.
- Rp_Zero  input  1  high when register-file read port A equals zero.
- PC_Out  output  PC_W  program counter and ROM address.
- IR_Out  output  IR_W  instruction register.
- StateO  output  4  current FSM state code.
- D_Addr  output  DA_W  data-memory address.
- D_Wr  output  1  data-memory write enable.
- RF_s  output  1  register-file write mux: 1 = data memory, 0 = ALU.
- RF_W_Addr  output  RA_W  register-file write address.
- RF_W_en  output  1  register-file write enable.
- RF_Ra_Addr  output  RA_W  read port A address.
- RF_Rb_Addr  output  RA_W  read port B address.
- ALU_s0  output  3  ALU function: 0 pass A, 1 add, 2 subtract.
- Halted  output  1  high while in HALT.

Behaviour:
- Reset (synchronous, Clk edge with Reset=1): state=INIT, PC=0, IR=0. All strobes and addresses 0, Halted=0. Reset has priority in every state, including mid-LOAD and HALT.
- State codes: INIT 0, FETCH 1, DECODE 2, NOOP 3, LOAD_A 4, LOAD_B 5, STORE 6, ADD 7, SUB 8, HALT 9, JMPZ 10. Codes 11-15 unused; if reached, go to INIT.
- Outputs decode combinationally from state and IR only. Any strobe not listed for a state is 0; addresses are 0 unless listed.
- Opcode = IR[15:12]: 0 NOOP, 1 STORE, 2 LOAD, 3 ADD, 4 SUB, 5 HALT, 6 JMPZ (feature-gated). All others behave as NOOP.
- INIT -> FETCH.
- FETCH: IR <= IM_Data; PC <= PC+1, wrapping 31 -> 0 (modulo 2^PC_W). -> DECODE.
- DECODE: no strobes; dispatch to the opcode state.
- NOOP -> FETCH.
- LOAD_A: D_Addr=IR[11:4], RF_s=1, RF_W_Addr=IR[3:0]. Data memory is synchronous read, 1-cycle latency. -> LOAD_B.
- LOAD_B: same outputs as LOAD_A plus RF_W_en=1. -> FETCH.
- STORE: RF_Ra_Addr=IR[11:8], D_Addr=IR[7:0], D_Wr=1. -> FETCH.
- ADD: RF_Ra_Addr=IR[11:8], RF_Rb_Addr=IR[7:4], RF_W_Addr=IR[3:0], RF_W_en=1, RF_s=0, ALU_s0=1. -> FETCH.
- SUB: as ADD with ALU_s0=2.
- HALT: Halted=1; PC and IR frozen; remain until Reset.
- Instruction latency: NOOP/STORE/ADD/SUB 3 cycles, LOAD 4 cycles, fetch to fetch.
- IR and PC change only in FETCH (and JMPZ when enabled).

Optional Feature:
- Macro: PROCESSOR_CTRL_JMPZ_EN.
- Defined:
  - Opcode 6 -> JMPZ.
  - JMPZ drives RF_Ra_Addr=IR[11:8].
  - If Rp_Zero=1, PC <= IR[PC_W-1:0]; otherwise PC unchanged.
  - -> FETCH. 3 cycles.
- Undefined:
  - Opcode 6 executes as NOOP; state 10 is unreachable.
  - Rp_Zero port remains present and is ignored.

Decomposition:
- Package processor_pkg:
  - opcode constants (OP_NOOP..OP_JMPZ)
  - state-code constants (S_INIT..S_JMPZ)
  - ALU function codes (ALU_PASS, ALU_ADD, ALU_SUB)
  - IR field bit positions
- Natural sub-module: processor_pc (PC register with reset, increment, and load). FSM and output decoder stay in processor_controller.

Test Plan:
- Reset held 2 cycles, then released -> StateO sequence 0,1,2; PC_Out=0 during INIT; PC_Out=1 after FETCH.
- IM_Data=16'h2AB3 (LOAD) -> LOAD_A then LOAD_B: D_Addr=8'hAB, RF_s=1, RF_W_Addr=3; RF_W_en=1 only in LOAD_B; next state FETCH.
- IM_Data=16'h3125 (ADD) -> RF_Ra_Addr=1, RF_Rb_Addr=2, RF_W_Addr=5, ALU_s0=1, RF_W_en=1 for exactly 1 cycle. 16'h4125 -> identical but ALU_s0=2.
- IM_Data=16'h1C40 (STORE) -> RF_Ra_Addr=12, D_Addr=8'h40, D_Wr=1 for 1 cycle. 32 consecutive NOOPs -> PC wraps 31 -> 0.
- IM_Data=16'h5000 (HALT) -> Halted=1, StateO=9 held 20 cycles, PC unchanged. Reset during HALT -> StateO=0, PC=0 on next edge.
- With PROCESSOR_CTRL_JMPZ_EN:
  - 16'h6007, Rp_Zero=1 -> PC=7.
  - Rp_Zero=0 -> PC unchanged.
  - Without macro, 16'h6007 -> NOOP path (state 3).

Source files
------------

// File: rtl/processor_pkg.sv
// Shared constants for the 16-bit processor control unit: opcodes, FSM state
// codes, ALU function codes and instruction field positions.
package processor_pkg;

  localparam logic [3:0] OP_NOOP  = 4'd0;
  localparam logic [3:0] OP_STORE = 4'd1;
  localparam logic [3:0] OP_LOAD  = 4'd2;
  localparam logic [3:0] OP_ADD   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_HALT  = 4'd5;
  localparam logic [3:0] OP_JMPZ  = 4'd6;

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9,
    S_JMPZ   = 4'd10
  } state_t;

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;

  // Instruction field bit positions
  localparam int OP_HI    = 15;
  localparam int OP_LO    = 12;
  localparam int RA_HI    = 11;
  localparam int RA_LO    = 8;
  localparam int RB_HI    = 7;
  localparam int RB_LO    = 4;
  localparam int WA_HI    = 3;
  localparam int WA_LO    = 0;
  localparam int LD_DA_HI = 11;
  localparam int LD_DA_LO = 4;
  localparam int ST_DA_HI = 7;
  localparam int ST_DA_LO = 0;

  function automatic logic [3:0] ir_opcode(input logic [15:0] ir);
    return ir[OP_HI:OP_LO];
  endfunction

endpackage

// File: rtl/processor_pc.sv
// Program counter: synchronous reset, modulo-2^PC_W increment and direct load.
module processor_pc #(
  parameter int PC_W = 5
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            inc,
  input  logic            load,
  input  logic [PC_W-1:0] load_val,
  output logic [PC_W-1:0] pc
);

  // Load wins over increment; the FSM never asserts both together.
  always_ff @(posedge Clk) begin
    if (Reset)     pc <= '0;
    else if (load) pc <= load_val;
    else if (inc)  pc <= pc + 1'b1;
  end

endmodule

// File: rtl/processor_controller.sv
// Moore control unit: owns PC and IR, fetches/decodes and drives datapath strobes.
// Optional conditional jump enabled by defining PROCESSOR_CTRL_JMPZ_EN.
import processor_pkg::*;

module processor_controller #(
  parameter int PC_W = 5,
  parameter int IR_W = 16,
  parameter int DA_W = 8,
  parameter int RA_W = 4
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic [IR_W-1:0] IM_Data,
  input  logic            Rp_Zero,
  output logic [PC_W-1:0] PC_Out,
  output logic [IR_W-1:0] IR_Out,
  output logic [3:0]      StateO,
  output logic [DA_W-1:0] D_Addr,
  output logic            D_Wr,
  output logic            RF_s,
  output logic [RA_W-1:0] RF_W_Addr,
  output logic            RF_W_en,
  output logic [RA_W-1:0] RF_Ra_Addr,
  output logic [RA_W-1:0] RF_Rb_Addr,
  output logic [2:0]      ALU_s0,
  output logic            Halted
);

  state_t          state_q, state_d;
  logic [IR_W-1:0] ir_q;
  logic            pc_inc, pc_load;
  logic [3:0]      op;

  assign op     = ir_opcode(ir_q);
  assign IR_Out = ir_q;
  assign StateO = state_q;

  processor_pc #(.PC_W(PC_W)) u_pc (
    .Clk      (Clk),
    .Reset    (Reset),
    .inc      (pc_inc),
    .load     (pc_load),
    .load_val (ir_q[PC_W-1:0]),
    .pc       (PC_Out)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_INIT;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_FETCH) ir_q <= IM_Data;
    end
  end

`ifndef PROCESSOR_CTRL_JMPZ_EN
  logic unused_rp_zero;
  assign unused_rp_zero = Rp_Zero;
`endif

  always_comb begin
    state_d    = S_INIT;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    D_Addr     = '0;
    D_Wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_Addr  = '0;
    RF_W_en    = 1'b0;
    RF_Ra_Addr = '0;
    RF_Rb_Addr = '0;
    ALU_s0     = ALU_PASS;
    Halted     = 1'b0;
    case (state_q)
      S_INIT:  state_d = S_FETCH;
      S_FETCH: begin
        pc_inc  = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        case (op)
          OP_STORE: state_d = S_STORE;
          OP_LOAD:  state_d = S_LOAD_A;
          OP_ADD:   state_d = S_ADD;
          OP_SUB:   state_d = S_SUB;
          OP_HALT:  state_d = S_HALT;
`ifdef PROCESSOR_CTRL_JMPZ_EN
          OP_JMPZ:  state_d = S_JMPZ;
`endif
          default:  state_d = S_NOOP;
        endcase
      end
      S_NOOP: state_d = S_FETCH;
      // Data memory reads take a cycle, so the write-back lands in LOAD_B.
      S_LOAD_A, S_LOAD_B: begin
        D_Addr    = ir_q[LD_DA_HI:LD_DA_LO];
        RF_s      = 1'b1;
        RF_W_Addr = ir_q[WA_HI:WA_LO];
        RF_W_en   = (state_q == S_LOAD_B);
        state_d   = (state_q == S_LOAD_A) ? S_LOAD_B : S_FETCH;
      end
      S_STORE: begin
        RF_Ra_Addr = ir_q[RA_HI:RA_LO];
        D_Addr     = ir_q[ST_DA_HI:ST_DA_LO];
        D_Wr       = 1'b1;
        state_d    = S_FETCH;
      end
      S_ADD, S_SUB: begin
        RF_Ra_Addr = ir_q[RA_HI:RA_LO];
        RF_Rb_Addr = ir_q[RB_HI:RB_LO];
        RF_W_Addr  = ir_q[WA_HI:WA_LO];
        RF_W_en    = 1'b1;
        ALU_s0     = (state_q == S_ADD) ? ALU_ADD : ALU_SUB;
        state_d    = S_FETCH;
      end
      S_HALT: begin
        Halted  = 1'b1;
        state_d = S_HALT;
      end
`ifdef PROCESSOR_CTRL_JMPZ_EN
      S_JMPZ: begin
        RF_Ra_Addr = ir_q[RA_HI:RA_LO];
        pc_load    = Rp_Zero;
        state_d    = S_FETCH;
      end
`endif
      default: state_d = S_INIT;
    endcase
  end

endmodule

// File: tb/tb_processor_controller.sv
// Scoreboard bench: an instruction-level model expands each program into the
// expected per-cycle control outputs; a monitor compares them against the DUT.
module tb_processor_controller;

  typedef struct packed {
    logic [3:0]  st;
    logic [4:0]  pc;
    logic [15:0] ir;
    logic [7:0]  da;
    logic        dwr;
    logic        rfs;
    logic [3:0]  wa;
    logic        wen;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [2:0]  alu;
    logic        halted;
  } rec_t;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [15:0] IM_Data;
  logic        Rp_Zero;
  logic [4:0]  PC_Out;
  logic [15:0] IR_Out;
  logic [3:0]  StateO;
  logic [7:0]  D_Addr;
  logic        D_Wr, RF_s, RF_W_en, Halted;
  logic [3:0]  RF_W_Addr, RF_Ra_Addr, RF_Rb_Addr;
  logic [2:0]  ALU_s0;

  logic [15:0] rom  [32];
  logic        zmap [32];
  rec_t        exp_q[$];
  logic        mon_en = 1'b0;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 Clk = ~Clk;

  assign IM_Data = rom[PC_Out];
  assign Rp_Zero = zmap[PC_Out];

  processor_controller dut (
    .Clk(Clk), .Reset(Reset), .IM_Data(IM_Data), .Rp_Zero(Rp_Zero),
    .PC_Out(PC_Out), .IR_Out(IR_Out), .StateO(StateO), .D_Addr(D_Addr),
    .D_Wr(D_Wr), .RF_s(RF_s), .RF_W_Addr(RF_W_Addr), .RF_W_en(RF_W_en),
    .RF_Ra_Addr(RF_Ra_Addr), .RF_Rb_Addr(RF_Rb_Addr), .ALU_s0(ALU_s0),
    .Halted(Halted)
  );

  // Monitor: one expected record per clock while the scoreboard holds entries.
  always @(posedge Clk) begin
    rec_t a, e;
    #1;
    if (mon_en && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a.st = StateO; a.pc = PC_Out; a.ir = IR_Out; a.da = D_Addr;
      a.dwr = D_Wr; a.rfs = RF_s; a.wa = RF_W_Addr; a.wen = RF_W_en;
      a.ra = RF_Ra_Addr; a.rb = RF_Rb_Addr; a.alu = ALU_s0; a.halted = Halted;
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL cycle t=%0t state=%0d: got %h, expected %h", $time, StateO, a, e);
      end
    end
  end

  // Reference model: walk the program instruction by instruction.
  task automatic build_exp(input int n, input int hold);
    rec_t        r;
    logic [4:0]  p = '0;
    logic [15:0] q = '0;
    r = '0;
    exp_q.push_back(r);
    exp_q.push_back(r);
    for (int i = 0; i < n; i++) begin
      r = '0; r.st = 4'd1; r.pc = p; r.ir = q;
      exp_q.push_back(r);
      q = rom[p];
      p = p + 5'd1;
      r = '0; r.st = 4'd2; r.pc = p; r.ir = q;
      exp_q.push_back(r);
      r = '0; r.pc = p; r.ir = q;
      case (q[15:12])
        4'd2: begin
          r.st = 4'd4; r.da = q[11:4]; r.rfs = 1'b1; r.wa = q[3:0];
          exp_q.push_back(r);
          r.st = 4'd5; r.wen = 1'b1;
          exp_q.push_back(r);
        end
        4'd1: begin
          r.st = 4'd6; r.ra = q[11:8]; r.da = q[7:0]; r.dwr = 1'b1;
          exp_q.push_back(r);
        end
        4'd3, 4'd4: begin
          r.st = (q[15:12] == 4'd3) ? 4'd7 : 4'd8;
          r.ra = q[11:8]; r.rb = q[7:4]; r.wa = q[3:0]; r.wen = 1'b1;
          r.alu = (q[15:12] == 4'd3) ? 3'd1 : 3'd2;
          exp_q.push_back(r);
        end
        4'd5: begin
          r.st = 4'd9; r.halted = 1'b1;
          for (int k = 0; k < hold; k++) exp_q.push_back(r);
          return;
        end
`ifdef PROCESSOR_CTRL_JMPZ_EN
        4'd6: begin
          r.st = 4'd10; r.ra = q[11:8];
          exp_q.push_back(r);
          if (zmap[p]) p = q[4:0];
        end
`endif
        default: begin
          r.st = 4'd3;
          exp_q.push_back(r);
        end
      endcase
    end
  endtask

  // ROM/zmap must already be loaded; resets DUT for 2 cycles and drains scoreboard.
  task automatic run_prog(input int n, input int hold);
    int cyc;
    @(negedge Clk);
    Reset = 1'b1;
    exp_q.delete();
    build_exp(n, hold);
    mon_en = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 1000) begin
      @(negedge Clk);
      cyc++;
    end
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d records left, expected 0", exp_q.size());
    end
    mon_en = 1'b0;
  endtask

  task automatic fill(input logic [15:0] ins, input logic z);
    for (int k = 0; k < 32; k++) begin
      rom[k]  = ins;
      zmap[k] = z;
    end
  endtask

  initial begin
    Reset = 1'b1;
    fill(16'h0000, 1'b0);

    // Directed: LOAD, ADD, SUB, STORE, JMPZ taken (jumps to HALT at 7), HALT held 20
    fill(16'h0000, 1'b1);
    rom[0] = 16'h2AB3; rom[1] = 16'h3125; rom[2] = 16'h4125;
    rom[3] = 16'h1C40; rom[4] = 16'h6007; rom[7] = 16'h5000;
    run_prog(20, 20);

    // Same program with JMPZ not taken
    for (int k = 0; k < 32; k++) zmap[k] = 1'b0;
    run_prog(20, 20);

    // 34 NOOPs: PC wraps 31 -> 0
    fill(16'h0000, 1'b0);
    run_prog(34, 0);

    // Random programs
    for (int t = 0; t < 10; t++) begin
      for (int k = 0; k < 32; k++) begin
        rom[k]  = 16'($urandom);
        zmap[k] = 1'($urandom);
      end
      run_prog(25, int'($urandom_range(1, 6)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
